// File: rtl/axi_stream_output.sv
// axi_stream_output
//   AXI4-Stream master that drains a contiguous region of a selected on-chip
//   SRAM to the host DMA, one element per beat, with tlast on the final one.
//   A 2-entry skid buffer hides the 1-cycle SRAM read latency and absorbs
//   downstream back-pressure while still sustaining one beat per cycle.
//
// Ports
//   m_axis_aclk    clock
//   m_axis_areset  asynchronous active-high reset, clears all state
//   start_i        one-cycle transfer request, honoured only when idle
//   base_addr_i    first SRAM address (latched on accepted start)
//   length_i       element count (latched on accepted start, 0 = no beats)
//   sram_sel_i     SRAM index to read (latched on accepted start)
//   sram_sel_o     latched SRAM index, to the SRAM mux
//   sram_re_o      SRAM read enable (combinational)
//   sram_raddr_o   SRAM read address (combinational, wraps modulo 2^ADDR_WIDTH)
//   sram_rdata_i   SRAM read data, valid one cycle after sram_re_o
//   m_axis_*       AXI4-Stream master channel (tdata/tstrb/tvalid/tready/tlast)
//   busy_o         high while a transfer is running
//   done_o         one-cycle pulse after the last beat (or after a 0-length start)
module axi_stream_output #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 8
) (
  input  logic                    m_axis_aclk,
  input  logic                    m_axis_areset,
  input  logic                    start_i,
  input  logic [ADDR_WIDTH-1:0]   base_addr_i,
  input  logic [ADDR_WIDTH-1:0]   length_i,
  input  logic [2:0]              sram_sel_i,
  output logic [2:0]              sram_sel_o,
  output logic                    sram_re_o,
  output logic [ADDR_WIDTH-1:0]   sram_raddr_o,
  input  logic [DATA_WIDTH-1:0]   sram_rdata_i,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tstrb,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic                    busy_o,
  output logic                    done_o
);

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   base_q;
  logic [ADDR_WIDTH-1:0]   len_q;
  logic [2:0]              sel_q;
  logic [ADDR_WIDTH-1:0]   rd_idx;
  logic [ADDR_WIDTH-1:0]   tx_idx;
  logic                    inflight;
  logic                    inflight_last;
  logic [DATA_WIDTH-1:0]   buf_data [2];
  logic [1:0]              buf_last;
  logic                    wr_ptr;
  logic                    rd_ptr;
  logic [1:0]              occ;
  logic                    done_q;

  logic                    pop;
  logic                    issue;
  logic [2:0]              fill;
  logic [2:0]              room;
  logic [ADDR_WIDTH-1:0]   len_m1;

  assign len_m1 = len_q - ONE;

  // A read may only be issued if, after this cycle's pop, the buffer plus the
  // read already in flight still leaves a free slot for the new data. The
  // comparison is rearranged to (occ + inflight) < (2 + pop) to stay unsigned.
  assign fill  = {1'b0, occ} + {2'b00, inflight};
  assign room  = 3'd2 + {2'b00, pop};
  assign issue = (state == ST_RUN) && (rd_idx < len_q) && (fill < room);

  assign sram_re_o    = issue;
  assign sram_raddr_o = base_q + rd_idx;
  assign sram_sel_o   = sel_q;

  assign m_axis_tvalid = (occ != 2'd0);
  assign m_axis_tdata  = buf_data[rd_ptr];
  assign m_axis_tlast  = m_axis_tvalid & buf_last[rd_ptr];
  assign m_axis_tstrb  = {(DATA_WIDTH/8){m_axis_tvalid}};
  assign pop           = m_axis_tvalid & m_axis_tready;

  assign busy_o = (state == ST_RUN);
  assign done_o = done_q;

  always_ff @(posedge m_axis_aclk or posedge m_axis_areset) begin
    if (m_axis_areset) begin
      state         <= ST_IDLE;
      base_q        <= '0;
      len_q         <= '0;
      sel_q         <= '0;
      rd_idx        <= '0;
      tx_idx        <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        buf_data[i] <= '0;
      end
      buf_last      <= '0;
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      occ           <= 2'd0;
      done_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (start_i) begin
            if (length_i != '0) begin
              base_q <= base_addr_i;
              len_q  <= length_i;
              sel_q  <= sram_sel_i;
              rd_idx <= '0;
              tx_idx <= '0;
              state  <= ST_RUN;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          // The handshake of the final element ends the transfer; by then
          // every issued read has been consumed, so the buffer is empty.
          if (pop && (tx_idx == len_m1)) begin
            state  <= ST_IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Tag the element at issue time so the capture side needs no index.
      inflight      <= issue;
      inflight_last <= (rd_idx == len_m1);
      if (issue) begin
        rd_idx <= rd_idx + ONE;
      end

      if (pop) begin
        tx_idx <= tx_idx + ONE;
        rd_ptr <= ~rd_ptr;
      end

      if (inflight) begin
        buf_data[wr_ptr] <= sram_rdata_i;
        buf_last[wr_ptr] <= inflight_last;
        wr_ptr           <= ~wr_ptr;
      end

      case ({inflight, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_stream_output.sv
// tb_axi_stream_output
//   Directed bench for axi_stream_output. A behavioural SRAM with one cycle of
//   read latency feeds the DUT; a negedge monitor records beats, reads and
//   done pulses, and checks stall stability. Expected values come from the
//   bench's own memory image and hand-computed cycle offsets.
module tb_axi_stream_output;

  localparam int AW = 13;
  localparam int DW = 8;

  logic          clk;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] length;
  logic [2:0]    sel_in;
  logic [2:0]    sel_out;
  logic          sram_re;
  logic [AW-1:0] sram_raddr;
  logic [DW-1:0] sram_rdata;
  logic [DW-1:0] tdata;
  logic [0:0]    tstrb;
  logic          tvalid;
  logic          tready;
  logic          tlast;
  logic          busy;
  logic          done;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  logic [DW-1:0] beat_data [$];
  bit            beat_last [$];
  int            beat_cyc  [$];
  logic [AW-1:0] re_addr   [$];
  int            re_cyc    [$];
  int            done_cnt;
  int            done_cyc;

  bit            prev_stall;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  axi_stream_output #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .m_axis_aclk   (clk),
    .m_axis_areset (rst),
    .start_i       (start),
    .base_addr_i   (base_addr),
    .length_i      (length),
    .sram_sel_i    (sel_in),
    .sram_sel_o    (sel_out),
    .sram_re_o     (sram_re),
    .sram_raddr_o  (sram_raddr),
    .sram_rdata_i  (sram_rdata),
    .m_axis_tdata  (tdata),
    .m_axis_tstrb  (tstrb),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .m_axis_tlast  (tlast),
    .busy_o        (busy),
    .done_o        (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural SRAM: data appears one cycle after the read enable.
  always @(posedge clk) begin
    if (sram_re) sram_rdata <= mem[sram_raddr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               tag, observed, expected, cyc);
    end
  endtask

  // Mid-cycle monitor: records handshakes, reads and done pulses, and
  // requires the head beat to hold steady across a stall.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checkOutput("stall_tvalid", 32'(tvalid), 32'd1);
        checkOutput("stall_tdata", 32'(tdata), 32'(prev_data));
        checkOutput("stall_tlast", 32'(tlast), 32'(prev_last));
      end
      if (tvalid && tready) begin
        beat_data.push_back(tdata);
        beat_last.push_back(tlast);
        beat_cyc.push_back(cyc);
      end
      if (sram_re) begin
        re_addr.push_back(sram_raddr);
        re_cyc.push_back(cyc);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = tvalid && !tready;
      prev_data  = tdata;
      prev_last  = tlast;
    end
  end

  // mode 0: tready high; 1: tready 1,0,0,1 repeating; 2: stray start during
  // the transfer; 3: reset asserted after three beats.
  task automatic applyStimulus(input logic [AW-1:0] b, input logic [AW-1:0] l,
                               input logic [2:0] s, input int mode,
                               output int s_cyc);
    beat_data.delete();
    beat_last.delete();
    beat_cyc.delete();
    re_addr.delete();
    re_cyc.delete();
    done_cnt = 0;
    done_cyc = -1;
    @(posedge clk); #1;
    start     = 1'b1;
    base_addr = b;
    length    = l;
    sel_in    = s;
    tready    = 1'b1;
    s_cyc     = cyc;
    for (int k = 1; k < 80; k++) begin
      @(posedge clk); #1;
      if (done_cnt != 0) begin
        start = 1'b0;
        break;
      end
      start = 1'b0;
      if (mode == 1) tready = ((k % 4) == 0) || ((k % 4) == 3);
      if (mode == 2 && k == 4) begin
        start     = 1'b1;
        base_addr = 13'h0200;
        length    = 13'd2;
        sel_in    = 3'd7;
      end
      if (mode == 3 && k == 6) begin
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_tvalid", 32'(tvalid), 32'd0);
        checkOutput("rst_mid_busy", 32'(busy), 32'd0);
        checkOutput("rst_mid_done", 32'(done), 32'd0);
        checkOutput("rst_mid_tlast", 32'(tlast), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        break;
      end
    end
    tready = 1'b1;
  endtask

  task automatic checkBeats(input logic [AW-1:0] b, input logic [AW-1:0] l);
    logic [AW-1:0] a;
    checkOutput("beat_count", 32'(beat_data.size()), 32'(l));
    for (int i = 0; i < beat_data.size() && i < int'(l); i++) begin
      a = b + AW'(i);
      checkOutput("beat_data", 32'(beat_data[i]), 32'(mem[a]));
      checkOutput("beat_last", 32'(beat_last[i]), 32'(i == int'(l) - 1));
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int s;
    logic [7:0] basic_exp [4];
    logic [AW-1:0] wrap_exp [4];

    basic_exp = '{8'h11, 8'h22, 8'h33, 8'h44};
    wrap_exp  = '{13'h1FFE, 13'h1FFF, 13'h0000, 13'h0001};

    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'(i * 7 + 3);
    mem[13'h010] = 8'h11;
    mem[13'h011] = 8'h22;
    mem[13'h012] = 8'h33;
    mem[13'h013] = 8'h44;
    mem[13'h1FFE] = 8'hA1;
    mem[13'h1FFF] = 8'hA2;
    mem[13'h0000] = 8'hA3;
    mem[13'h0001] = 8'hA4;

    clk = 1'b0; rst = 1'b1; start = 1'b0; base_addr = '0; length = '0;
    sel_in = '0; tready = 1'b1; sram_rdata = '0;
    done_cnt = 0; done_cyc = -1; prev_stall = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_tvalid", 32'(tvalid), 32'd0);
    checkOutput("reset_tstrb", 32'(tstrb), 32'd0);
    checkOutput("reset_tlast", 32'(tlast), 32'd0);
    checkOutput("reset_tdata", 32'(tdata), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_re", 32'(sram_re), 32'd0);
    checkOutput("reset_sel", 32'(sel_out), 32'd0);
    rst = 1'b0;

    // Basic: beats in cycles 3..6, done in cycle 7.
    applyStimulus(13'h010, 13'd4, 3'd5, 0, s);
    checkOutput("basic_count", 32'(beat_data.size()), 32'd4);
    for (int i = 0; i < beat_data.size() && i < 4; i++) begin
      checkOutput("basic_data", 32'(beat_data[i]), 32'(basic_exp[i]));
      checkOutput("basic_last", 32'(beat_last[i]), 32'(i == 3));
      checkOutput("basic_beat_cycle", 32'(beat_cyc[i] - s), 32'(3 + i));
    end
    checkOutput("basic_first_re_cycle", 32'(re_cyc.size() > 0 ? re_cyc[0] - s : -1), 32'd1);
    checkOutput("basic_first_raddr", 32'(re_addr.size() > 0 ? re_addr[0] : '1), 32'h010);
    checkOutput("basic_done_count", 32'(done_cnt), 32'd1);
    checkOutput("basic_done_cycle", 32'(done_cyc - s), 32'd7);
    checkOutput("basic_sel", 32'(sel_out), 32'd5);
    checkOutput("basic_busy_after", 32'(busy), 32'd0);

    // Back-pressure.
    applyStimulus(13'h040, 13'd8, 3'd2, 1, s);
    checkBeats(13'h040, 13'd8);
    checkOutput("bp_done_count", 32'(done_cnt), 32'd1);
    checkOutput("bp_read_count", 32'(re_addr.size()), 32'd8);

    // Single element.
    applyStimulus(13'h020, 13'd1, 3'd1, 0, s);
    checkBeats(13'h020, 13'd1);
    checkOutput("single_done_count", 32'(done_cnt), 32'd1);
    checkOutput("single_done_cycle", 32'(done_cyc - s), 32'd4);

    // Zero length: no reads, no beats, done one cycle after start.
    applyStimulus(13'h030, 13'd0, 3'd3, 0, s);
    checkOutput("zero_beats", 32'(beat_data.size()), 32'd0);
    checkOutput("zero_reads", 32'(re_addr.size()), 32'd0);
    checkOutput("zero_done_count", 32'(done_cnt), 32'd1);
    checkOutput("zero_done_cycle", 32'(done_cyc - s), 32'd1);

    // Address wrap.
    applyStimulus(13'h1FFE, 13'd4, 3'd4, 0, s);
    checkBeats(13'h1FFE, 13'd4);
    checkOutput("wrap_read_count", 32'(re_addr.size()), 32'd4);
    for (int i = 0; i < re_addr.size() && i < 4; i++) begin
      checkOutput("wrap_raddr", 32'(re_addr[i]), 32'(wrap_exp[i]));
    end
    checkOutput("wrap_data0", 32'(beat_data.size() > 2 ? beat_data[2] : '0), 32'h0A3);

    // Stray start mid-transfer must not disturb the stream.
    applyStimulus(13'h100, 13'd6, 3'd6, 2, s);
    checkBeats(13'h100, 13'd6);
    checkOutput("ign_done_count", 32'(done_cnt), 32'd1);
    checkOutput("ign_sel", 32'(sel_out), 32'd6);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("ign_busy_after", 32'(busy), 32'd0);
    checkOutput("ign_read_count", 32'(re_addr.size()), 32'd6);

    // Reset after three of ten beats, then a clean two-beat transfer.
    applyStimulus(13'h300, 13'd10, 3'd2, 3, s);
    checkOutput("rst_beats", 32'(beat_data.size()), 32'd3);
    for (int i = 0; i < beat_data.size() && i < 3; i++) begin
      checkOutput("rst_data", 32'(beat_data[i]), 32'(mem[13'h300 + AW'(i)]));
    end
    checkOutput("rst_done_count", 32'(done_cnt), 32'd0);
    checkOutput("rst_sel_cleared", 32'(sel_out), 32'd0);

    applyStimulus(13'h400, 13'd2, 3'd1, 0, s);
    checkBeats(13'h400, 13'd2);
    checkOutput("post_rst_done_count", 32'(done_cnt), 32'd1);
    checkOutput("post_rst_done_cycle", 32'(done_cyc - s), 32'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
